// File: rtl/lx_mem_arbiter_pkg.sv
// Shared types and helpers for the L1-miss to iomem arbiter.
package lx_mem_arbiter_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Width of a starvation counter able to hold 0..limit; at least one bit.
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/lx_mem_arbiter_pick.sv
// Combinational masked priority picker: first valid bit at or after i_start,
// wrapping, returned as one-hot and as an index.
module lx_mem_arbiter_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Circular scan from i_start; the first valid position wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [IW-1:0] pos;
            pos = IW'((32'(i_start) + k) % N);
            if (!o_any && i_valid[pos]) begin
                o_any        = 1'b1;
                o_grant[pos] = 1'b1;
                o_idx        = pos;
            end
        end
    end

endmodule

// File: rtl/lx_mem_arbiter.sv
// N-port arbiter between L1 miss requesters and the single iomem bus.
// One transaction in flight; round-robin or fixed priority with starvation guard.
module lx_mem_arbiter
    import lx_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BLK_W        = 128,
    parameter int unsigned STRB_W       = BLK_W / 8,
    parameter arb_mode_e   ARB_MODE     = ARB_RR,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS*STRB_W-1:0]   req_wstrb_i,
    input  logic [NUM_PORTS*BLK_W-1:0]    req_wdata_i,
    output logic [NUM_PORTS-1:0]          res_valid_o,
    output logic [BLK_W-1:0]              res_rdata_o,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic                          mem_valid_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [STRB_W-1:0]             mem_wstrb_o,
    output logic [BLK_W-1:0]              mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic [BLK_W-1:0]              mem_rdata_i
);

    localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = starve_cnt_w(STARVE_LIMIT);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   w_accept;
    logic                   w_complete;

    logic [NUM_PORTS-1:0]   r_grant;
    logic [NUM_PORTS-1:0]   r_res_valid;
    logic [BLK_W-1:0]       r_rdata;
    logic [ADDR_W-1:0]      r_addr;
    logic [STRB_W-1:0]      r_wstrb;
    logic [BLK_W-1:0]       r_wdata;
    logic [IW-1:0]          r_rr_ptr;
    logic [CW-1:0]          r_starve [NUM_PORTS];

    logic [NUM_PORTS-1:0]   w_starved;
    logic [NUM_PORTS-1:0]   w_pick_valid;
    logic [IW-1:0]          w_pick_start;
    logic [NUM_PORTS-1:0]   w_pick_grant;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [STRB_W-1:0]      w_sel_wstrb;
    logic [BLK_W-1:0]       w_sel_wdata;

    // Picker inputs: RR starts after the last winner; fixed mode scans from 0,
    // restricted to starved requesters whenever any exist.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_starved[p] = (STARVE_LIMIT != 0) && req_valid_i[p] &&
                           (r_starve[p] == CW'(STARVE_LIMIT));
        end
        if (ARB_MODE == ARB_RR) begin
            w_pick_valid = req_valid_i;
            w_pick_start = (r_rr_ptr == IW'(NUM_PORTS - 1)) ? '0 : r_rr_ptr + 1'b1;
        end else begin
            w_pick_valid = (|w_starved) ? w_starved : req_valid_i;
            w_pick_start = '0;
        end
    end

    lx_mem_arbiter_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .i_valid (w_pick_valid),
        .i_start (w_pick_start),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // One-hot mux of the winner's payload.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wstrb = '0;
        w_sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_pick_grant[p]) begin
                w_sel_addr  = req_addr_i[p*ADDR_W +: ADDR_W];
                w_sel_wstrb = req_wstrb_i[p*STRB_W +: STRB_W];
                w_sel_wdata = req_wdata_i[p*BLK_W +: BLK_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) r_state <= ARB_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state and iomem request strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        mem_valid_o = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // Request payload, captured on grant and held for the whole REQ phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= w_sel_addr;
            r_wstrb <= w_sel_wstrb;
            r_wdata <= w_sel_wdata;
        end
    end

    // Grant ownership, completion pulse and response data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant     <= '0;
            r_res_valid <= '0;
            r_rdata     <= '0;
        end else begin
            r_res_valid <= '0;
            if (w_accept)                 r_grant <= w_pick_grant;
            else if (r_state == ARB_RESP) r_grant <= '0;
            if (w_complete) begin
                r_res_valid <= r_grant;
                r_rdata     <= mem_rdata_i;
            end
        end
    end

    // Round-robin pointer follows the last winner; reset makes port 0 win first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_rr_ptr <= IW'(NUM_PORTS - 1);
        else if (w_accept) r_rr_ptr <= w_pick_idx;
    end

    // Starvation counters: losers that keep requesting climb toward the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this small counter array is control state, not a RAM, so each entry is reset explicitly.
            for (int p = 0; p < NUM_PORTS; p++) r_starve[p] <= '0;
        end else if (w_accept && (ARB_MODE == ARB_FIXED) && (STARVE_LIMIT != 0)) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_pick_grant[p])                         r_starve[p] <= '0;
                else if (!req_valid_i[p])                    r_starve[p] <= '0;
                else if (r_starve[p] != CW'(STARVE_LIMIT))   r_starve[p] <= r_starve[p] + 1'b1;
            end
        end
    end

    assign grant_o     = r_grant;
    assign res_valid_o = r_res_valid;
    assign res_rdata_o = r_rdata;
    assign mem_addr_o  = r_addr;
    assign mem_wstrb_o = r_wstrb;
    assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_lx_mem_arbiter.sv
// Scoreboard bench: 2-port RR, 3-port fixed-priority and 4-port RR instances.
module tb_lx_mem_arbiter;
    import lx_mem_arbiter_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic [15:0]  wstrb;
        logic [127:0] wdata;
    } req_t;

    typedef struct {
        int           port;
        logic [127:0] rdata;
        bit           chk_data;
        int           cyc;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        bit          is_rd;
    } r4_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // 2-port RR instance
    logic [1:0]   d_req_valid;
    logic [63:0]  d_req_addr;
    logic [31:0]  d_req_wstrb;
    logic [255:0] d_req_wdata;
    logic [1:0]   d_res_valid;
    logic [127:0] d_res_rdata;
    logic [1:0]   d_grant;
    logic         d_mem_valid;
    logic [31:0]  d_mem_addr;
    logic [15:0]  d_mem_wstrb;
    logic [127:0] d_mem_wdata;
    logic         d_mem_ready;
    logic [127:0] d_mem_rdata;

    // 3-port fixed-priority instance
    logic [2:0]   f_req_valid;
    logic [95:0]  f_req_addr;
    logic [47:0]  f_req_wstrb;
    logic [383:0] f_req_wdata;
    logic [2:0]   f_res_valid;
    logic [127:0] f_res_rdata;
    logic [2:0]   f_grant;
    logic         f_mem_valid;
    logic [31:0]  f_mem_addr;
    logic [15:0]  f_mem_wstrb;
    logic [127:0] f_mem_wdata;
    logic         f_mem_ready;
    logic [127:0] f_mem_rdata;

    // 4-port RR instance
    logic [3:0]   r4_req_valid;
    logic [127:0] r4_req_addr;
    logic [63:0]  r4_req_wstrb;
    logic [511:0] r4_req_wdata;
    logic [3:0]   r4_res_valid;
    logic [127:0] r4_res_rdata;
    logic [3:0]   r4_grant;
    logic         r4_mem_valid;
    logic [31:0]  r4_mem_addr;
    logic [15:0]  r4_mem_wstrb;
    logic [127:0] r4_mem_wdata;
    logic         r4_mem_ready;
    logic [127:0] r4_mem_rdata;

    lx_mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(ARB_RR)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(d_req_valid), .req_addr_i(d_req_addr),
        .req_wstrb_i(d_req_wstrb), .req_wdata_i(d_req_wdata),
        .res_valid_o(d_res_valid), .res_rdata_o(d_res_rdata), .grant_o(d_grant),
        .mem_valid_o(d_mem_valid), .mem_addr_o(d_mem_addr),
        .mem_wstrb_o(d_mem_wstrb), .mem_wdata_o(d_mem_wdata),
        .mem_ready_i(d_mem_ready), .mem_rdata_i(d_mem_rdata)
    );

    lx_mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(2)) u_fx (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(f_req_valid), .req_addr_i(f_req_addr),
        .req_wstrb_i(f_req_wstrb), .req_wdata_i(f_req_wdata),
        .res_valid_o(f_res_valid), .res_rdata_o(f_res_rdata), .grant_o(f_grant),
        .mem_valid_o(f_mem_valid), .mem_addr_o(f_mem_addr),
        .mem_wstrb_o(f_mem_wstrb), .mem_wdata_o(f_mem_wdata),
        .mem_ready_i(f_mem_ready), .mem_rdata_i(f_mem_rdata)
    );

    lx_mem_arbiter #(.NUM_PORTS(4), .ARB_MODE(ARB_RR)) u_r4 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(r4_req_valid), .req_addr_i(r4_req_addr),
        .req_wstrb_i(r4_req_wstrb), .req_wdata_i(r4_req_wdata),
        .res_valid_o(r4_res_valid), .res_rdata_o(r4_res_rdata), .grant_o(r4_grant),
        .mem_valid_o(r4_mem_valid), .mem_addr_o(r4_mem_addr),
        .mem_wstrb_o(r4_mem_wstrb), .mem_wdata_o(r4_mem_wdata),
        .mem_ready_i(r4_mem_ready), .mem_rdata_i(r4_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory content seen by the 4-port instance, a function of the address.
    function automatic logic [127:0] mem_fn(input logic [31:0] a);
        return {a, ~a, a ^ 32'hDEAD_BEEF, a + 32'd1};
    endfunction

    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- 2-port scoreboard ----------------
    req_t         d_q_req[$];
    res_t         d_q_res[$];
    res_t         d_e;
    int           d_delay = 1;
    int           d_vcnt = 0;
    logic [127:0] d_data = '0;
    int           d_res_seen = 0;

    // Memory model: checks payload every REQ cycle, answers after d_delay cycles.
    always @(negedge clk) begin
        if (d_mem_valid) begin
            if (d_q_req.size() == 0) begin
                check("mem_req_unexpected", 1'b1, 1'b0);
            end else begin
                check("mem_addr",  d_mem_addr,  d_q_req[0].addr);
                check("mem_wstrb", d_mem_wstrb, d_q_req[0].wstrb);
                check("mem_wdata", d_mem_wdata, d_q_req[0].wdata);
            end
            d_vcnt++;
            d_mem_ready = (d_vcnt >= d_delay);
            d_mem_rdata = d_mem_ready ? d_data : {4{32'hBAD0_BAD0}};
            if (d_mem_ready && d_q_req.size() != 0) void'(d_q_req.pop_front());
        end else begin
            d_vcnt      = 0;
            d_mem_ready = 1'b0;
            d_mem_rdata = {4{32'hBAD0_BAD0}};
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (d_grant != 0) check("grant_onehot0", 128'($onehot0(d_grant)), 1);
            if (d_res_valid != 0) begin
                d_res_seen++;
                check("res_onehot", 128'($onehot(d_res_valid)), 1);
                check("res_grant_match", 128'((d_res_valid & d_grant) == d_res_valid), 1);
                if (d_q_res.size() == 0) begin
                    check("res_unexpected", d_res_valid, 0);
                end else begin
                    d_e = d_q_res.pop_front();
                    check("res_port", d_res_valid, 128'(2'b01 << d_e.port));
                    if (d_e.chk_data) check("res_rdata", d_res_rdata, d_e.rdata);
                    if (d_e.cyc >= 0)  check("res_cycle", cyc, d_e.cyc);
                end
            end
        end
    end

    task automatic wait_res(input int target, input int budget, input string name);
        int n = 0;
        while (d_res_seen < target && n < budget) begin
            tick();
            n++;
        end
        check(name, d_res_seen, target);
    endtask

    // ---------------- 3-port fixed-priority scoreboard ----------------
    int f_q_port[$];
    int f_res_seen = 0;
    int f_exp;

    assign f_mem_ready = f_mem_valid;
    assign f_mem_rdata = '0;

    always @(negedge clk) begin
        if (rst_n && f_res_valid != 0) begin
            f_res_seen++;
            check("fx_grant_match", 128'((f_res_valid & f_grant) == f_res_valid), 1);
            if (f_q_port.size() == 0) begin
                check("fx_res_unexpected", f_res_valid, 0);
            end else begin
                f_exp = f_q_port.pop_front();
                check("fx_res_port", f_res_valid, 128'(3'b001 << f_exp));
            end
        end
    end

    // ---------------- 4-port random scoreboard ----------------
    r4_t      r4_q[4][$];
    r4_t      r4_e;
    int       r4_issued[4];
    int       r4_done[4];
    int       r4_wait[4];
    bit       r4_granted[4];
    logic [3:0] r4_prev_grant = '0;
    logic [3:0] r4_prev_valid = '0;
    int       r4_delay = 1;
    int       r4_vcnt = 0;

    assign r4_mem_rdata = mem_fn(r4_mem_addr);

    always @(negedge clk) begin
        if (r4_mem_valid) begin
            if (r4_vcnt == 0) r4_delay = $urandom_range(1, 4);
            r4_vcnt++;
            r4_mem_ready = (r4_vcnt >= r4_delay);
        end else begin
            r4_vcnt      = 0;
            r4_mem_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (r4_grant != 0 && r4_prev_grant == 0) begin
                check("r4_grant_onehot", 128'($onehot(r4_grant)), 1);
                for (int p = 0; p < 4; p++) begin
                    if (r4_grant[p]) begin
                        check("r4_grant_was_valid", r4_prev_valid[p], 1'b1);
                        check("r4_wait_bound", 128'(r4_wait[p] <= 3), 1);
                        r4_granted[p] = 1'b1;
                        r4_wait[p]    = 0;
                    end else if (r4_prev_valid[p] && !r4_granted[p]) begin
                        r4_wait[p]++;
                    end
                end
            end
            if (r4_res_valid != 0) begin
                check("r4_res_onehot", 128'($onehot(r4_res_valid)), 1);
                check("r4_res_grant_match", 128'((r4_res_valid & r4_grant) == r4_res_valid), 1);
                for (int p = 0; p < 4; p++) begin
                    if (r4_res_valid[p]) begin
                        if (r4_q[p].size() == 0) begin
                            check("r4_res_unexpected", r4_res_valid, 0);
                        end else begin
                            r4_e = r4_q[p].pop_front();
                            if (r4_e.is_rd) check("r4_rdata", r4_res_rdata, mem_fn(r4_e.addr));
                        end
                        r4_done[p]++;
                        r4_granted[p] = 1'b0;
                    end
                end
            end
        end
        r4_prev_grant = r4_grant;
        r4_prev_valid = r4_req_valid;
    end

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c0;
        int n0;
        bit all_idle;
        rst_n        = 1'b0;
        d_req_valid  = '0; d_req_addr = '0; d_req_wstrb = '0; d_req_wdata = '0;
        f_req_valid  = '0; f_req_addr = '0; f_req_wstrb = '0; f_req_wdata = '0;
        r4_req_valid = '0; r4_req_addr = '0; r4_req_wstrb = '0; r4_req_wdata = '0;
        for (int p = 0; p < 4; p++) begin
            r4_issued[p] = 0; r4_done[p] = 0; r4_wait[p] = 0; r4_granted[p] = 1'b0;
        end
        repeat (3) tick();
        check("rst_mem_valid", d_mem_valid, 0);
        check("rst_grant",     d_grant, 0);
        check("rst_res_valid", d_res_valid, 0);
        check("rst_mem_addr",  d_mem_addr, 0);
        check("rst_res_rdata", d_res_rdata, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset in the middle of REQ drops the transaction.
        d_delay = 20;
        d_q_req.push_back('{addr: 32'h0000_0100, wstrb: '0, wdata: '0});
        d_req_addr[31:0] = 32'h0000_0100;
        d_req_valid      = 2'b01;
        n0 = 0;
        while (!d_mem_valid && n0 < 10) begin tick(); n0++; end
        check("t1_mem_valid", d_mem_valid, 1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("t1_rst_mem_valid", d_mem_valid, 0);
        check("t1_rst_res_valid", d_res_valid, 0);
        check("t1_rst_grant",     d_grant, 0);
        d_req_valid = '0;
        d_q_req.delete();
        n0 = d_res_seen;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t1_no_stray_res", d_res_seen, n0);

        // RR with both ports valid: 0,1,0,1 every 4 cycles.
        d_delay = 2;
        d_data  = {4{32'h1111_2222}};
        d_req_addr = {32'h0000_3000, 32'h0000_2000};
        for (int i = 0; i < 4; i++)
            d_q_req.push_back('{addr: (i % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000, wstrb: '0, wdata: '0});
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            d_q_res.push_back('{port: i % 2, rdata: {4{32'h1111_2222}}, chk_data: 1'b1, cyc: c0 + 3 + 4 * i});
        d_req_valid = 2'b11;
        wait_res(d_res_seen + 4, 60, "t2_four_res");
        d_req_valid = '0;
        repeat (3) tick();

        // Read on port 1 returning the A5 pattern.
        d_delay = 1;
        d_data  = {16{8'hA5}};
        d_req_addr[63:32] = 32'h8000_0040;
        d_q_req.push_back('{addr: 32'h8000_0040, wstrb: '0, wdata: '0});
        c0 = cyc;
        d_q_res.push_back('{port: 1, rdata: {16{8'hA5}}, chk_data: 1'b1, cyc: c0 + 2});
        d_req_valid = 2'b10;
        tick();
        check("t3_mem_valid_latency", d_mem_valid, 1);
        wait_res(d_res_seen + 1, 20, "t3_res");
        d_req_valid = '0;
        repeat (3) tick();

        // Write on port 0 with a 10-cycle memory stall.
        d_delay = 10;
        d_data  = '0;
        d_req_addr[31:0]    = 32'h0000_1000;
        d_req_wstrb[15:0]   = 16'h00F0;
        d_req_wdata[127:0]  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d_q_req.push_back('{addr: 32'h0000_1000, wstrb: 16'h00F0,
                            wdata: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});
        c0 = cyc;
        d_q_res.push_back('{port: 0, rdata: '0, chk_data: 1'b0, cyc: c0 + 11});
        d_req_valid = 2'b01;
        wait_res(d_res_seen + 1, 40, "t4_res");
        d_req_valid = '0;
        n0 = d_res_seen;
        repeat (6) tick();
        check("t4_single_res", d_res_seen, n0);
        check("t4_queues_empty", 128'(d_q_req.size() + d_q_res.size()), 0);

        // Fixed priority, limit 2, ports 0 and 2 always valid.
        f_q_port = '{0, 0, 2, 0, 0, 2};
        f_req_valid = 3'b101;
        n0 = 0;
        while (f_res_seen < 6 && n0 < 60) begin tick(); n0++; end
        f_req_valid = '0;
        check("t5_six_res", f_res_seen, 6);
        repeat (4) tick();
        check("t5_queue_empty", f_q_port.size(), 0);

        // Random 4-port RR traffic.
        for (int t = 0; t < 400; t++) begin
            tick();
            for (int p = 0; p < 4; p++) begin
                if (r4_issued[p] == r4_done[p]) begin
                    if (r4_req_valid[p]) begin
                        r4_req_valid[p] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        logic [31:0] a;
                        bit          wr;
                        a  = $urandom & 32'hFFFF_FFF0;
                        wr = ($urandom_range(0, 3) == 0);
                        r4_req_addr[p*32 +: 32]   = a;
                        r4_req_wstrb[p*16 +: 16]  = wr ? (16'($urandom) | 16'h0001) : 16'h0000;
                        r4_req_wdata[p*128 +: 128] = {4{$urandom}};
                        r4_q[p].push_back('{addr: a, is_rd: !wr});
                        r4_issued[p]++;
                        r4_req_valid[p] = 1'b1;
                    end
                end
            end
        end
        all_idle = 1'b0;
        for (int t = 0; t < 200 && !all_idle; t++) begin
            tick();
            all_idle = 1'b1;
            for (int p = 0; p < 4; p++) begin
                if (r4_issued[p] == r4_done[p]) r4_req_valid[p] = 1'b0;
                else                            all_idle = 1'b0;
            end
        end
        check("t6_drained", all_idle, 1'b1);
        for (int p = 0; p < 4; p++) begin
            check("t6_port_queue_empty", r4_q[p].size(), 0);
            check("t6_port_active", 128'(r4_issued[p] > 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
